tile_scheduler_v2: RTL and testbench
====================================

// Module: tile_scheduler_v2
// PURPOSE
//  Parametrised successor tile scheduler: walks K (outer) -> D -> N (inner) tile loops with runtime remainders.
//  Issues multi-burst DMA descriptors for weight/ifmap/bias/ipsum loads and opsum writeback, and starts token-engine passes.
//  Sits between the layer-descriptor decoder and the DMA engine / token engine.
// PARAMETERS
//  ADDR_W  32  DRAM byte-address width; all address math is modulo 2^ADDR_W
//  DIM_W   16  width of channel/pixel counts and tile sizes
//  LEN_W   24  DMA burst length width (bytes)
//  BYTES_I 1   ifmap element bytes;  BYTES_W 1 weight bytes;  BYTES_B 4 bias bytes;  BYTES_P 4 psum bytes
// PORTS
//  clk             in   1       clock; all logic on posedge
//  rst             in   1       synchronous, active-high reset
//  start_i         in   1       latch descriptor, begin layer (ignored while busy_o=1)
//  dw_i            in   1       depthwise: D loop collapsed, no ipsum, weight burst = K_real*BYTES_W
//  bias_en_i       in   1       load bias on first D tile of each K tile
//  num_K_i/num_D_i/num_N_i  in  DIM_W  output channels / input channels / output pixels
//  tile_K_i/tile_D_i/tile_N_i in DIM_W  max tile sizes (must be >0)
//  base_w_i/base_i_i/base_b_i/base_o_i in ADDR_W  DRAM bases: weight[K][D], ifmap[D][N], bias[K], ofmap/psum[K][N]
//  dma_req_o       out  1       burst request valid; held until dma_ack_i
//  dma_write_o     out  1       1=GLB->DRAM, 0=DRAM->GLB
//  dma_addr_o      out  ADDR_W  burst DRAM address
//  dma_len_o       out  LEN_W   burst length bytes
//  dma_ack_i       in   1       request accepted this cycle
//  dma_done_i      in   1       accepted burst complete (1-cycle pulse)
//  pass_start_o    out  1       1-cycle pulse starting a pass
//  pass_done_i     in   1       pass complete pulse
//  k_real_o/d_real_o/n_real_o out DIM_W  current tile extents
//  psum_in_o       out  1       current pass accumulates onto loaded ipsum (d0!=0)
//  busy_o          out  1       layer in progress
//  layer_done_o    out  1       1-cycle pulse after final writeback done
// BEHAVIOUR
//  Reset: state IDLE; all outputs and counters 0.
//  States: IDLE, TILE (compute reals, 1 cycle), LD_W, LD_I, LD_B, LD_P, PASS, WB, DONE.
//  IDLE --start_i--> TILE; if any num_*==0 go straight to DONE (no DMA, no pass).
//  Reals: X_real = min(tile_X, num_X - X0); X0 = completed count of that loop.
//  TILE -> LD_W only when n0==0 (new K/D pair); else LD_I. Order: LD_W, LD_I, LD_B (bias_en & d0==0), LD_P (d0!=0 & !dw), PASS.
//  Bursts per load (b = burst index):
//   LD_W: K_real bursts, addr base_w+((k0+b)*num_D+d0)*BYTES_W, len D_real*BYTES_W (dw: 1 burst, base_w+k0*BYTES_W, len K_real*BYTES_W)
//   LD_I: D_real bursts (dw: K_real, d0:=k0), addr base_i+((d0+b)*num_N+n0)*BYTES_I, len N_real*BYTES_I
//   LD_B: 1 burst, base_b+k0*BYTES_B, len K_real*BYTES_B
//   LD_P / WB: K_real bursts, base_o+((k0+b)*num_N+n0)*BYTES_P, len N_real*BYTES_P; WB has dma_write_o=1
//  Handshake: per burst, assert dma_req_o with addr/len stable until ack; then wait dma_done_i; next burst no earlier than cycle after done.
//   ack and done in same cycle are legal (zero-latency DMA): treated as accept+complete.
//  PASS: pass_start_o pulses on entry cycle only; wait pass_done_i -> WB. WB every tile (psum spill when not last D).
//  Advance after WB done: n0+=N_real; on n wrap n0=0,d0+=D_real; on d wrap d0=0,k0+=K_real; on k wrap -> DONE. dw: d loop one iteration.
//  DONE: layer_done_o=1 one cycle, busy_o drops same cycle, -> IDLE.
//  start_i while busy ignored; descriptor inputs sampled only at start.
//  rst mid-burst: dma_req_o and pass_start_o drop next edge, no further bursts; DMA engine must be reset alongside.
// TESTING
//  PW K=4,D=4,N=8, tiles 4/4/8 -> 4 W bursts len4, 4 I bursts len8, 1 pass, 4 WB bursts len32 @base_o+{0,32,64,96}, layer_done.
//  K=5,D=3,N=10 tiles 2/2/4 -> K_real 2,2,1; D_real 2,1; N_real 4,4,2; 18 passes; LD_P only when d0=2.
//  bias_en, K=4,D=4 tile_D=2 -> bias burst len16 on d0=0 only, absent on d0=2.
//  dw K=3,N=4 tile_K=4 -> 1 W burst len3, 3 I bursts, no LD_P, 1 pass.
//  dma_ack delayed 3 cycles, ack+done same cycle -> addr/len stable while req high, no burst lost/duplicated.
//  num_N=0 -> layer_done one cycle after start, zero dma_req; rst during LD_I -> outputs 0 next cycle, restart works.

Source files
------------

// File: rtl/tile_scheduler_v2_if.sv
// DMA descriptor and token-engine pass handshake between the tile scheduler and its engines.
interface tile_scheduler_v2_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 24
);
    logic              dma_req_o;
    logic              dma_write_o;
    logic [ADDR_W-1:0] dma_addr_o;
    logic [LEN_W-1:0]  dma_len_o;
    logic              dma_ack_i;
    logic              dma_done_i;
    logic              pass_start_o;
    logic              pass_done_i;

    modport master (
        output dma_req_o, dma_write_o, dma_addr_o, dma_len_o, pass_start_o,
        input  dma_ack_i, dma_done_i, pass_done_i
    );
    modport slave (
        input  dma_req_o, dma_write_o, dma_addr_o, dma_len_o, pass_start_o,
        output dma_ack_i, dma_done_i, pass_done_i
    );
endinterface

// File: rtl/tile_scheduler_v2.sv
// Walks K -> D -> N tile loops with remainders, issuing multi-burst DMA loads,
// token-engine passes and opsum writeback for one layer.
module tile_scheduler_v2 #(
    parameter int ADDR_W  = 32,
    parameter int DIM_W   = 16,
    parameter int LEN_W   = 24,
    parameter int BYTES_I = 1,
    parameter int BYTES_W = 1,
    parameter int BYTES_B = 4,
    parameter int BYTES_P = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              dw_i,
    input  logic              bias_en_i,
    input  logic [DIM_W-1:0]  num_K_i,
    input  logic [DIM_W-1:0]  num_D_i,
    input  logic [DIM_W-1:0]  num_N_i,
    input  logic [DIM_W-1:0]  tile_K_i,
    input  logic [DIM_W-1:0]  tile_D_i,
    input  logic [DIM_W-1:0]  tile_N_i,
    input  logic [ADDR_W-1:0] base_w_i,
    input  logic [ADDR_W-1:0] base_i_i,
    input  logic [ADDR_W-1:0] base_b_i,
    input  logic [ADDR_W-1:0] base_o_i,
    tile_scheduler_v2_if.master dma,
    output logic [DIM_W-1:0]  k_real_o,
    output logic [DIM_W-1:0]  d_real_o,
    output logic [DIM_W-1:0]  n_real_o,
    output logic              psum_in_o,
    output logic              busy_o,
    output logic              layer_done_o
);
    typedef enum logic [3:0] {IDLE, TILE, LD_W, LD_I, LD_B, LD_P, PASS, WB, DONE} state_t;
    state_t state, nxt;

    logic              dw_q, bias_q;
    logic [DIM_W-1:0]  num_k, num_d, num_n, tile_k, tile_d, tile_n;
    logic [ADDR_W-1:0] base_w, base_i, base_b, base_o;
    logic [DIM_W-1:0]  k0, d0, n0, b_idx, n_bursts;
    logic              wait_done, pass_started;
    logic              is_dma, burst_done, last_burst, layer_end;
    logic [DIM_W:0]    k_sum, d_sum, n_sum;
    logic [DIM_W-1:0]  rem_k, rem_d, rem_n;
    logic [ADDR_W-1:0] row_ko, row_i, addr;
    logic [LEN_W-1:0]  len;

    assign is_dma     = state inside {LD_W, LD_I, LD_B, LD_P, WB};
    // ack+done in the same cycle completes the burst without a wait state
    assign burst_done = is_dma && dma.dma_done_i && (wait_done || dma.dma_ack_i);
    assign last_burst = (b_idx == n_bursts - DIM_W'(1));

    assign rem_k = num_k - k0;
    assign rem_d = num_d - d0;
    assign rem_n = num_n - n0;
    assign k_sum = {1'b0, k0} + {1'b0, k_real_o};
    assign d_sum = {1'b0, d0} + {1'b0, d_real_o};
    assign n_sum = {1'b0, n0} + {1'b0, n_real_o};
    assign layer_end = (n_sum >= {1'b0, num_n}) && (dw_q || d_sum >= {1'b0, num_d})
                       && (k_sum >= {1'b0, num_k});

    assign dma.dma_req_o    = is_dma && !wait_done;
    assign dma.dma_write_o  = (state == WB);
    assign dma.dma_addr_o   = addr;
    assign dma.dma_len_o    = len;
    assign dma.pass_start_o = (state == PASS) && !pass_started;
    assign psum_in_o        = (d0 != '0) && !dw_q;
    assign busy_o           = (state != IDLE) && (state != DONE);
    assign layer_done_o     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (start_i)
                      nxt = (num_K_i == '0 || num_D_i == '0 || num_N_i == '0) ? DONE : TILE;
            TILE: nxt = (n0 == '0) ? LD_W : LD_I;
            LD_W: if (burst_done && last_burst) nxt = LD_I;
            LD_I: if (burst_done && last_burst)
                      nxt = (bias_q && d0 == '0) ? LD_B : (d0 != '0 && !dw_q) ? LD_P : PASS;
            LD_B, LD_P: if (burst_done && last_burst) nxt = PASS;
            PASS: if (dma.pass_done_i) nxt = WB;
            WB:   if (burst_done && last_burst) nxt = layer_end ? DONE : TILE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Depthwise reuses the K index as the ifmap channel index.
    assign row_ko = ADDR_W'(k0) + ADDR_W'(b_idx);
    assign row_i  = (dw_q ? ADDR_W'(k0) : ADDR_W'(d0)) + ADDR_W'(b_idx);

    always_comb begin
        addr     = '0;
        len      = '0;
        n_bursts = k_real_o;
        case (state)
            LD_W: begin
                n_bursts = dw_q ? DIM_W'(1) : k_real_o;
                addr = dw_q ? base_w + ADDR_W'(k0) * ADDR_W'(BYTES_W)
                            : base_w + (row_ko * ADDR_W'(num_d) + ADDR_W'(d0)) * ADDR_W'(BYTES_W);
                len  = (dw_q ? LEN_W'(k_real_o) : LEN_W'(d_real_o)) * LEN_W'(BYTES_W);
            end
            LD_I: begin
                n_bursts = dw_q ? k_real_o : d_real_o;
                addr = base_i + (row_i * ADDR_W'(num_n) + ADDR_W'(n0)) * ADDR_W'(BYTES_I);
                len  = LEN_W'(n_real_o) * LEN_W'(BYTES_I);
            end
            LD_B: begin
                n_bursts = DIM_W'(1);
                addr = base_b + ADDR_W'(k0) * ADDR_W'(BYTES_B);
                len  = LEN_W'(k_real_o) * LEN_W'(BYTES_B);
            end
            LD_P, WB: begin
                addr = base_o + (row_ko * ADDR_W'(num_n) + ADDR_W'(n0)) * ADDR_W'(BYTES_P);
                len  = LEN_W'(n_real_o) * LEN_W'(BYTES_P);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dw_q <= 1'b0;  bias_q <= 1'b0;
            num_k <= '0;   num_d <= '0;   num_n <= '0;
            tile_k <= '0;  tile_d <= '0;  tile_n <= '0;
            base_w <= '0;  base_i <= '0;  base_b <= '0;  base_o <= '0;
            k0 <= '0;  d0 <= '0;  n0 <= '0;  b_idx <= '0;
            k_real_o <= '0;  d_real_o <= '0;  n_real_o <= '0;
            wait_done <= 1'b0;  pass_started <= 1'b0;
        end else begin
            pass_started <= (state == PASS);
            if (state == IDLE && start_i) begin
                dw_q <= dw_i;  bias_q <= bias_en_i;
                num_k <= num_K_i;   num_d <= num_D_i;   num_n <= num_N_i;
                tile_k <= tile_K_i; tile_d <= tile_D_i; tile_n <= tile_N_i;
                base_w <= base_w_i; base_i <= base_i_i; base_b <= base_b_i; base_o <= base_o_i;
                k0 <= '0;  d0 <= '0;  n0 <= '0;  b_idx <= '0;  wait_done <= 1'b0;
            end
            if (state == TILE) begin
                k_real_o <= (tile_k < rem_k) ? tile_k : rem_k;
                d_real_o <= (tile_d < rem_d) ? tile_d : rem_d;
                n_real_o <= (tile_n < rem_n) ? tile_n : rem_n;
            end
            if (is_dma) begin
                if (burst_done) begin
                    wait_done <= 1'b0;
                    b_idx     <= last_burst ? '0 : b_idx + DIM_W'(1);
                end else if (dma.dma_req_o && dma.dma_ack_i) begin
                    wait_done <= 1'b1;
                end
            end
            if (state == WB && burst_done && last_burst) begin
                if (n_sum < {1'b0, num_n}) begin
                    n0 <= n_sum[DIM_W-1:0];
                end else begin
                    n0 <= '0;
                    if (!dw_q && d_sum < {1'b0, num_d}) begin
                        d0 <= d_sum[DIM_W-1:0];
                    end else begin
                        d0 <= '0;
                        k0 <= k_sum[DIM_W-1:0];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tile_scheduler_v2.sv
// Directed bench: a loop-nest model queues expected bursts/passes; a DMA/engine responder pops and compares.
module tb_tile_scheduler_v2;
    localparam int ADDR_W = 32, DIM_W = 16, LEN_W = 24;
    localparam logic [31:0] BW = 32'h1000, BI = 32'h2000, BB = 32'h3000, BO = 32'h4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start, dw, bias_en;
    logic [DIM_W-1:0] nK, nD, nN, tK, tD, tN, k_real, d_real, n_real;
    logic [ADDR_W-1:0] bw, bi, bb, bo;
    logic psum_in, busy, layer_done;

    tile_scheduler_v2_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    tile_scheduler_v2 dut (
        .clk(clk), .rst(rst), .start_i(start), .dw_i(dw), .bias_en_i(bias_en),
        .num_K_i(nK), .num_D_i(nD), .num_N_i(nN), .tile_K_i(tK), .tile_D_i(tD), .tile_N_i(tN),
        .base_w_i(bw), .base_i_i(bi), .base_b_i(bb), .base_o_i(bo),
        .dma(bus.master), .k_real_o(k_real), .d_real_o(d_real), .n_real_o(n_real),
        .psum_in_o(psum_in), .busy_o(busy), .layer_done_o(layer_done)
    );

    typedef struct {
        bit          is_pass;
        bit          wr;
        logic [31:0] addr;
        logic [23:0] len;
        int          kr, dr, nr;
        bit          pin;
    } ev_t;

    ev_t sb[$];
    int  checks = 0, failures = 0, npass = 0, ack_dly = 0;
    bit  zero_lat = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_b(input bit wr, input int a, input int l);
        ev_t e;
        e = '{is_pass: 1'b0, wr: wr, addr: 32'(a), len: 24'(l), kr: 0, dr: 0, nr: 0, pin: 1'b0};
        sb.push_back(e);
    endfunction

    function automatic void push_p(input int kr, input int dr, input int nr, input bit pin);
        ev_t e;
        e = '{is_pass: 1'b1, wr: 1'b0, addr: '0, len: '0, kr: kr, dr: dr, nr: nr, pin: pin};
        sb.push_back(e);
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Expected event stream of a whole layer, in issue order.
    function automatic void model(input bit idw, input bit ib, input int K, input int D, input int N,
                                  input int TK, input int TD, input int TN);
        for (int k0 = 0; k0 < K; k0 += TK) begin
            for (int d0 = 0; d0 < (idw ? 1 : D); d0 += TD) begin
                for (int n0 = 0; n0 < N; n0 += TN) begin
                    int kr, dr, nr;
                    kr = min2(TK, K - k0);
                    dr = min2(TD, D - d0);
                    nr = min2(TN, N - n0);
                    if (n0 == 0) begin
                        if (idw) push_b(1'b0, int'(BW) + k0, kr);
                        else for (int b = 0; b < kr; b++) push_b(1'b0, int'(BW) + (k0 + b) * D + d0, dr);
                    end
                    for (int b = 0; b < (idw ? kr : dr); b++)
                        push_b(1'b0, int'(BI) + ((idw ? k0 : d0) + b) * N + n0, nr);
                    if (ib && d0 == 0) push_b(1'b0, int'(BB) + k0 * 4, kr * 4);
                    if (!idw && d0 != 0)
                        for (int b = 0; b < kr; b++) push_b(1'b0, int'(BO) + ((k0 + b) * N + n0) * 4, nr * 4);
                    push_p(kr, dr, nr, !idw && d0 != 0);
                    for (int b = 0; b < kr; b++) push_b(1'b1, int'(BO) + ((k0 + b) * N + n0) * 4, nr * 4);
                end
            end
        end
    endfunction

    task automatic drive(input bit idw, input bit ib, input int K, input int D, input int N,
                         input int TK, input int TD, input int TN);
        dw = idw; bias_en = ib;
        nK = 16'(K); nD = 16'(D); nN = 16'(N); tK = 16'(TK); tD = 16'(TD); tN = 16'(TN);
        bw = BW; bi = BI; bb = BB; bo = BO;
    endtask

    task automatic scramble();
        dw = ~dw; bias_en = ~bias_en;
        nK = 16'd9; nD = 16'd7; nN = 16'd5; tK = 16'd1; tD = 16'd1; tN = 16'd1;
        bw = 32'hdead0000; bi = 32'hbeef0000; bb = 32'hcafe0000; bo = 32'hf00d0000;
    endtask

    task automatic run_layer(input string tag, input bit idw, input bit ib, input int K, input int D,
                             input int N, input int TK, input int TD, input int TN,
                             input int exp_pass, output int cyc);
        model(idw, ib, K, D, N, TK, TD, TN);
        npass = 0;
        drive(idw, ib, K, D, N, TK, TD, TN);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        cyc = 1;
        while (!layer_done && cyc < 20000) begin
            start = (cyc == 4);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_layer_done"}, layer_done, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_sb_left"}, sb.size(), 0);
        chk({tag, "_passes"}, npass, exp_pass);
        @(negedge clk);
        chk({tag, "_done_pulse"}, layer_done, 0);
        sb.delete();
    endtask

    // DMA engine and token engine model.
    initial begin : responder
        int cnt, dcnt, pd;
        bit pend;
        logic [31:0] ha;
        logic [23:0] hl;
        ev_t e;
        cnt = 0; dcnt = 0; pd = 0; pend = 1'b0; ha = '0; hl = '0;
        bus.dma_ack_i = 1'b0; bus.dma_done_i = 1'b0; bus.pass_done_i = 1'b0;
        forever begin
            @(negedge clk);
            bus.dma_ack_i = 1'b0; bus.dma_done_i = 1'b0; bus.pass_done_i = 1'b0;
            if (rst) begin
                cnt = 0; pend = 1'b0; pd = 0;
            end else begin
                if (pend) begin
                    dcnt++;
                    if (dcnt == 2) begin bus.dma_done_i = 1'b1; pend = 1'b0; end
                end else if (bus.dma_req_o) begin
                    if (cnt == 0) begin
                        ha = bus.dma_addr_o; hl = bus.dma_len_o;
                        chk("req_expected", sb.size() != 0, 1);
                        if (sb.size() != 0) begin
                            e = sb[0];
                            chk("burst_kind", e.is_pass, 0);
                            chk("burst_write", bus.dma_write_o, e.wr);
                            chk("burst_addr", bus.dma_addr_o, e.addr);
                            chk("burst_len", bus.dma_len_o, e.len);
                        end
                    end else begin
                        chk("addr_stable", bus.dma_addr_o, ha);
                        chk("len_stable", bus.dma_len_o, hl);
                    end
                    if (cnt == ack_dly) begin
                        bus.dma_ack_i = 1'b1;
                        cnt = 0;
                        if (sb.size() != 0) void'(sb.pop_front());
                        if (zero_lat) bus.dma_done_i = 1'b1;
                        else begin pend = 1'b1; dcnt = 0; end
                    end else begin
                        cnt++;
                    end
                end
                if (pd > 0) begin
                    pd--;
                    if (pd == 0) bus.pass_done_i = 1'b1;
                end
                if (bus.pass_start_o) begin
                    chk("pass_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("pass_kind", e.is_pass, 1);
                        chk("pass_k_real", k_real, e.kr);
                        chk("pass_d_real", d_real, e.dr);
                        chk("pass_n_real", n_real, e.nr);
                        chk("pass_psum_in", psum_in, e.pin);
                    end
                    npass++;
                    pd = 3;
                end
            end
        end
    end

    initial begin : main
        int cyc;
        bit hit;
        start = 1'b0;
        drive(1'b0, 1'b0, 1, 1, 1, 1, 1, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_req", bus.dma_req_o, 0);
        chk("rst_pass_start", bus.pass_start_o, 0);
        chk("rst_layer_done", layer_done, 0);
        chk("rst_k_real", k_real, 0);
        chk("rst_psum_in", psum_in, 0);
        rst = 1'b0;
        @(negedge clk);

        ack_dly = 0; zero_lat = 1'b0;
        run_layer("pw_single", 1'b0, 1'b0, 4, 4, 8, 4, 4, 8, 1, cyc);
        ack_dly = 1;
        run_layer("remainders", 1'b0, 1'b0, 5, 3, 10, 2, 2, 4, 18, cyc);
        ack_dly = 0;
        run_layer("bias", 1'b0, 1'b1, 4, 4, 4, 4, 2, 4, 2, cyc);
        run_layer("dw", 1'b1, 1'b0, 3, 3, 4, 4, 4, 4, 1, cyc);
        ack_dly = 3; zero_lat = 1'b1;
        run_layer("slow_ack_zero_lat", 1'b0, 1'b1, 5, 3, 10, 2, 2, 4, 18, cyc);
        ack_dly = 0; zero_lat = 1'b0;
        run_layer("num_n_zero", 1'b0, 1'b0, 4, 4, 0, 4, 4, 8, 0, cyc);
        chk("num_n_zero_latency", cyc, 1);

        // Reset while the first ifmap burst is pending.
        ack_dly = 3;
        model(1'b0, 1'b0, 4, 4, 8, 4, 4, 8);
        drive(1'b0, 1'b0, 4, 4, 8, 4, 4, 8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (bus.dma_req_o && bus.dma_addr_o == BI) hit = 1'b1;
            else @(negedge clk);
        end
        chk("rst_mid_reached_ld_i", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", bus.dma_req_o, 0);
        chk("rst_mid_pass_start", bus.pass_start_o, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_k_real", k_real, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_quiet", bus.dma_req_o, 0);
        end
        ack_dly = 0;
        run_layer("restart", 1'b0, 1'b0, 4, 4, 8, 4, 4, 8, 1, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
